// File: rtl/mem_ctrl_pkg.sv
// Shared constants and helpers for the paged tracklet memory.
// Used by the write arbiter and the memory itself.
package mem_ctrl_pkg;

  localparam int NPAGE     = 8;
  localparam int PAGE_BITS = 3;
  localparam int NENT_BITS = 8;

  // Ceiling log2; clogb2(1) is 0.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_write_arbiter_rr_arb2.sv
// Two-way round-robin arbiter.
// Pointer names the requester that wins a tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr_q;
  logic ptr_d;

  // Grant from requests and pointer; pointer moves past the winner.
  always_comb begin
    gnt   = 2'b00;
    ptr_d = ptr_q;
    unique case (1'b1)
      (req == 2'b11): gnt = ptr_q ? 2'b10 : 2'b01;
      (req == 2'b01): gnt = 2'b01;
      (req == 2'b10): gnt = 2'b10;
      default:        gnt = 2'b00;
    endcase
    if (gnt[0]) ptr_d = 1'b1;
    if (gnt[1]) ptr_d = 1'b0;
  end

  // Pointer register; requester 0 wins first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_write_arbiter.sv
// Write-side controller for the paged tracklet memory.
// Arbitrates two requesters, allocates page slots, drives entry counts.
module mem_write_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int RAM_WIDTH  = 18,
  parameter int RAM_DEPTH  = 1024,
  parameter int PAGE_DEPTH = RAM_DEPTH / 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in0_valid,
  output logic                          in0_ready,
  input  logic [RAM_WIDTH-1:0]          in0_data,
  input  logic [2:0]                    in0_page,
  input  logic                          in1_valid,
  output logic                          in1_ready,
  input  logic [RAM_WIDTH-1:0]          in1_data,
  input  logic [2:0]                    in1_page,
  input  logic                          page_clr,
  input  logic [2:0]                    page_clr_idx,
  output logic [clogb2(RAM_DEPTH)-1:0]  addra,
  output logic [RAM_WIDTH-1:0]          dina,
  output logic                          wea,
  output logic [7:0]                    nent_i0,
  output logic [7:0]                    nent_i1,
  output logic [7:0]                    nent_i2,
  output logic [7:0]                    nent_i3,
  output logic [7:0]                    nent_i4,
  output logic [7:0]                    nent_i5,
  output logic [7:0]                    nent_i6,
  output logic [7:0]                    nent_i7,
  output logic                          nent_we0,
  output logic                          nent_we1,
  output logic                          nent_we2,
  output logic                          nent_we3,
  output logic                          nent_we4,
  output logic                          nent_we5,
  output logic                          nent_we6,
  output logic                          nent_we7,
  output logic                          drop,
  output logic [7:0]                    ovf
);

  localparam int AW = clogb2(RAM_DEPTH);
  localparam int PB = clogb2(PAGE_DEPTH);
  localparam logic [NENT_BITS-1:0] FULL = NENT_BITS'(PAGE_DEPTH);

  logic [1:0] req;
  logic [1:0] gnt;

  logic                 acc;
  logic [PAGE_BITS-1:0] acc_page;
  logic [RAM_WIDTH-1:0] acc_data;
  logic [NENT_BITS-1:0] acc_cnt;
  logic                 acc_full;

  logic [NENT_BITS-1:0] cnt_q [NPAGE];
  logic [NENT_BITS-1:0] cnt_d [NPAGE];
  logic [NPAGE-1:0]     ovf_q;
  logic [NPAGE-1:0]     ovf_d;

  logic [AW-1:0]        addra_q;
  logic [AW-1:0]        addra_d;
  logic [RAM_WIDTH-1:0] dina_q;
  logic [RAM_WIDTH-1:0] dina_d;
  logic                 wea_q;
  logic                 wea_d;
  logic                 drop_q;
  logic                 drop_d;
  logic [NENT_BITS-1:0] nent_q [NPAGE];
  logic [NENT_BITS-1:0] nent_d [NPAGE];
  logic [NPAGE-1:0]     nwe_q;
  logic [NPAGE-1:0]     nwe_d;

  assign req = {in1_valid, in0_valid};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign in0_ready = gnt[0];
  assign in1_ready = gnt[1];

  // Select the granted item and its effective count after any clear.
  always_comb begin
    acc      = |gnt;
    acc_page = gnt[1] ? in1_page : in0_page;
    acc_data = gnt[1] ? in1_data : in0_data;
    acc_cnt  = cnt_q[acc_page];
    if (page_clr && (page_clr_idx == acc_page)) acc_cnt = '0;
    acc_full = (acc_cnt >= FULL);
  end

  // Next state: clear first, then allocate or drop the accepted item.
  always_comb begin
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    nent_d  = nent_q;
    nwe_d   = '0;
    addra_d = addra_q;
    dina_d  = dina_q;
    wea_d   = 1'b0;
    drop_d  = 1'b0;
    if (page_clr) begin
      cnt_d[page_clr_idx]  = '0;
      ovf_d[page_clr_idx]  = 1'b0;
      nent_d[page_clr_idx] = '0;
      nwe_d[page_clr_idx]  = 1'b1;
    end
    if (acc) begin
      if (!acc_full) begin
        addra_d          = AW'({acc_page, acc_cnt[PB-1:0]});
        dina_d           = acc_data;
        wea_d            = 1'b1;
        cnt_d[acc_page]  = acc_cnt + 1'b1;
        nent_d[acc_page] = acc_cnt + 1'b1;
        nwe_d[acc_page]  = 1'b1;
      end else begin
        drop_d          = 1'b1;
        ovf_d[acc_page] = 1'b1;
      end
    end
  end

  // Page state and registered memory-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPAGE; i++) begin
        cnt_q[i]  <= '0;
        nent_q[i] <= '0;
      end
      ovf_q   <= '0;
      nwe_q   <= '0;
      addra_q <= '0;
      dina_q  <= '0;
      wea_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NPAGE; i++) begin
        cnt_q[i]  <= cnt_d[i];
        nent_q[i] <= nent_d[i];
      end
      ovf_q   <= ovf_d;
      nwe_q   <= nwe_d;
      addra_q <= addra_d;
      dina_q  <= dina_d;
      wea_q   <= wea_d;
      drop_q  <= drop_d;
    end
  end

  assign addra = addra_q;
  assign dina  = dina_q;
  assign wea   = wea_q;
  assign drop  = drop_q;
  assign ovf   = ovf_q;

  assign nent_i0 = nent_q[0];
  assign nent_i1 = nent_q[1];
  assign nent_i2 = nent_q[2];
  assign nent_i3 = nent_q[3];
  assign nent_i4 = nent_q[4];
  assign nent_i5 = nent_q[5];
  assign nent_i6 = nent_q[6];
  assign nent_i7 = nent_q[7];

  assign nent_we0 = nwe_q[0];
  assign nent_we1 = nwe_q[1];
  assign nent_we2 = nwe_q[2];
  assign nent_we3 = nwe_q[3];
  assign nent_we4 = nwe_q[4];
  assign nent_we5 = nwe_q[5];
  assign nent_we6 = nwe_q[6];
  assign nent_we7 = nwe_q[7];

endmodule

// File: tb/tb_mem_write_arbiter.sv
// Bench for mem_write_arbiter: page-level model plus directed vectors.
// Model is checked every cycle; literal expectations pin key points.
module tb_mem_write_arbiter;

  localparam int W  = 18;
  localparam int PD = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in0_valid = 1'b0;
  logic        in1_valid = 1'b0;
  logic        in0_ready;
  logic        in1_ready;
  logic [W-1:0] in0_data = '0;
  logic [W-1:0] in1_data = '0;
  logic [2:0]  in0_page = '0;
  logic [2:0]  in1_page = '0;
  logic        page_clr = 1'b0;
  logic [2:0]  page_clr_idx = '0;
  logic [9:0]  addra;
  logic [W-1:0] dina;
  logic        wea;
  logic [7:0]  nent_i0, nent_i1, nent_i2, nent_i3;
  logic [7:0]  nent_i4, nent_i5, nent_i6, nent_i7;
  logic        nent_we0, nent_we1, nent_we2, nent_we3;
  logic        nent_we4, nent_we5, nent_we6, nent_we7;
  logic        drop;
  logic [7:0]  ovf;

  logic [7:0]  ni [8];
  logic [7:0]  we;

  int checks = 0;
  int errors = 0;

  mem_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in0_data(in0_data), .in0_page(in0_page),
    .in1_valid(in1_valid), .in1_ready(in1_ready),
    .in1_data(in1_data), .in1_page(in1_page),
    .page_clr(page_clr), .page_clr_idx(page_clr_idx),
    .addra(addra), .dina(dina), .wea(wea),
    .nent_i0(nent_i0), .nent_i1(nent_i1),
    .nent_i2(nent_i2), .nent_i3(nent_i3),
    .nent_i4(nent_i4), .nent_i5(nent_i5),
    .nent_i6(nent_i6), .nent_i7(nent_i7),
    .nent_we0(nent_we0), .nent_we1(nent_we1),
    .nent_we2(nent_we2), .nent_we3(nent_we3),
    .nent_we4(nent_we4), .nent_we5(nent_we5),
    .nent_we6(nent_we6), .nent_we7(nent_we7),
    .drop(drop), .ovf(ovf)
  );

  always #5 clk = ~clk;

  assign ni[0] = nent_i0;
  assign ni[1] = nent_i1;
  assign ni[2] = nent_i2;
  assign ni[3] = nent_i3;
  assign ni[4] = nent_i4;
  assign ni[5] = nent_i5;
  assign ni[6] = nent_i6;
  assign ni[7] = nent_i7;
  assign we = {nent_we7, nent_we6, nent_we5, nent_we4,
               nent_we3, nent_we2, nent_we1, nent_we0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d",
               name, $time, act, exp);
    end
  endtask

  // Model state: per-page fill counts, overflow flags, tie pointer.
  int       m_cnt [8];
  bit [7:0] m_ovf = '0;
  bit       m_rr = 1'b0;
  bit       e_wea = 1'b0;
  bit       e_drop = 1'b0;
  int       e_addra = 0;
  int       e_dina = 0;
  bit [7:0] e_we = '0;
  int       e_ni [8];

  initial begin
    for (int i = 0; i < 8; i++) begin
      m_cnt[i] = 0;
      e_ni[i]  = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) begin
        m_cnt[i] = 0;
        e_ni[i]  = 0;
        chk($sformatf("rst_nent_i%0d", i), ni[i], 0);
      end
      m_ovf = '0; m_rr = 1'b0;
      e_wea = 1'b0; e_drop = 1'b0; e_we = '0;
      e_addra = 0; e_dina = 0;
      chk("rst_wea", wea, 0);
      chk("rst_drop", drop, 0);
      chk("rst_addra", addra, 0);
      chk("rst_dina", dina, 0);
      chk("rst_nent_we", we, 0);
      chk("rst_ovf", ovf, 0);
    end else begin
      bit g0, g1;
      int pg, dt;
      chk("wea", wea, e_wea);
      chk("drop", drop, e_drop);
      chk("nent_we", we, e_we);
      chk("ovf", ovf, m_ovf);
      if (e_wea) begin
        chk("addra", addra, e_addra);
        chk("dina", dina, e_dina);
      end
      for (int p = 0; p < 8; p++)
        if (e_we[p]) chk($sformatf("nent_i%0d", p), ni[p], e_ni[p]);
      g0 = 1'b0; g1 = 1'b0;
      if (in0_valid && in1_valid) begin
        if (m_rr) g1 = 1'b1; else g0 = 1'b1;
      end else begin
        g0 = in0_valid;
        g1 = in1_valid;
      end
      chk("in0_ready", in0_ready, g0);
      chk("in1_ready", in1_ready, g1);
      e_wea = 1'b0; e_drop = 1'b0; e_we = '0;
      if (page_clr) begin
        m_cnt[page_clr_idx] = 0;
        m_ovf[page_clr_idx] = 1'b0;
        e_ni[page_clr_idx]  = 0;
        e_we[page_clr_idx]  = 1'b1;
      end
      if (g0 || g1) begin
        pg = g1 ? int'(in1_page) : int'(in0_page);
        dt = g1 ? int'(in1_data) : int'(in0_data);
        if (m_cnt[pg] < PD) begin
          e_addra = pg * PD + m_cnt[pg];
          e_dina  = dt;
          e_wea   = 1'b1;
          m_cnt[pg] = m_cnt[pg] + 1;
          e_ni[pg]  = m_cnt[pg];
          e_we[pg]  = 1'b1;
        end else begin
          e_drop    = 1'b1;
          m_ovf[pg] = 1'b1;
        end
        m_rr = g0;
      end
    end
  end

  task automatic step(input bit v0, input int p0, input int d0,
                      input bit v1, input int p1, input int d1,
                      input bit clr, input int ci);
    in0_valid = v0; in0_page = 3'(p0); in0_data = W'(d0);
    in1_valid = v1; in1_page = 3'(p1); in1_data = W'(d1);
    page_clr = clr; page_clr_idx = 3'(ci);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle();

    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1, 2, 16'h2A0 + k, 0, 0);
      chk("t1_addra", addra, 256 + k);
      chk("t1_nent_i2", nent_i2, k + 1);
      chk("t1_nent_we2", nent_we2, 1);
    end
    idle();

    for (int k = 0; k < 6; k++) begin
      in0_valid = 1'b1; in0_page = 3'd0; in0_data = W'(18'h100);
      in1_valid = 1'b1; in1_page = 3'd1; in1_data = W'(18'h200);
      page_clr = 1'b0;
      #1;
      chk("t2_grant0", in0_ready, (k % 2 == 0) ? 1 : 0);
      chk("t2_grant1", in1_ready, (k % 2 == 1) ? 1 : 0);
      @(posedge clk);
      #1;
      if (k == 4) chk("t2_nent_i0", nent_i0, 3);
      if (k == 5) chk("t2_nent_i1", nent_i1, 3);
    end
    idle();

    for (int k = 0; k < PD; k++)
      step(1, 5, k, 0, 0, 0, 0, 0);
    chk("t3_fill_nent_i5", nent_i5, 128);
    chk("t3_fill_addra", addra, 767);
    step(1, 5, 18'h3FFFF, 0, 0, 0, 0, 0);
    chk("t3_ovf_wea", wea, 0);
    chk("t3_ovf_drop", drop, 1);
    chk("t3_ovf_flag", ovf[5], 1);
    chk("t3_ovf_nent_we5", nent_we5, 0);
    chk("t3_ovf_nent_i5", nent_i5, 128);

    step(1, 5, 18'h155, 0, 0, 0, 1, 5);
    chk("t4_addra", addra, 640);
    chk("t4_wea", wea, 1);
    chk("t4_nent_i5", nent_i5, 1);
    chk("t4_nent_we5", nent_we5, 1);
    chk("t4_ovf5", ovf[5], 0);
    chk("t4_drop", drop, 0);
    idle();

    step(1, 4, 18'h044, 0, 0, 0, 1, 3);
    chk("t5_nent_we3", nent_we3, 1);
    chk("t5_nent_we4", nent_we4, 1);
    chk("t5_nent_i3", nent_i3, 0);
    chk("t5_nent_i4", nent_i4, 1);
    chk("t5_addra", addra, 512);

    step(1, 6, 18'h066, 1, 7, 18'h077, 0, 0);
    step(1, 6, 18'h066, 1, 7, 18'h077, 0, 0);
    chk("t6_pre_wea", wea, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_wea", wea, 0);
    chk("t6_async_addra", addra, 0);
    chk("t6_async_nent_i6", nent_i6, 0);
    chk("t6_async_nent_we", we, 0);
    in0_valid = 1'b0; in1_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1, 0, 18'h0AB, 0, 0, 0, 0, 0);
    chk("t6_post_addra", addra, 0);
    chk("t6_post_wea", wea, 1);
    chk("t6_post_nent_i0", nent_i0, 1);
    idle();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
